// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, requests to send,
// then shifts start/data/parity/stop on device clock falling edges and reads the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic       oPS2_CLK_OE,
  output logic       oPS2_DAT_OE,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, FINISH} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      n_reg, n_next;
  logic [7:0]      data_reg, data_next;
  logic            parity_reg, parity_next;
  logic            nack_reg, nack_next;
  logic [1:0]      clk_sync_reg;
  logic            clk_prev_reg;
  logic [1:0]      dat_sync_reg;
  logic            fall;
  logic            dat_sync;
  logic [15:0]     frame_bits;

  // Synchronizers preset to the idle (released) level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_reg <= 2'b11;
      clk_prev_reg <= 1'b1;
      dat_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg <= {clk_sync_reg[0], iPS2_CLK};
      clk_prev_reg <= clk_sync_reg[1];
      dat_sync_reg <= {dat_sync_reg[0], iPS2_DAT};
    end
  end

  assign fall     = clk_prev_reg & ~clk_sync_reg[1];
  assign dat_sync = dat_sync_reg[1];

  // Bit driven after n falling edges: start, 8 data LSB first, parity; upper slots released.
  assign frame_bits = {6'b111111, parity_reg, data_reg, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      n_reg      <= '0;
      data_reg   <= '0;
      parity_reg <= 1'b0;
      nack_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      n_reg      <= n_next;
      data_reg   <= data_next;
      parity_reg <= parity_next;
      nack_reg   <= nack_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    n_next      = n_reg;
    data_next   = data_reg;
    parity_next = parity_reg;
    nack_next   = nack_reg;
    oPS2_CLK_OE = 1'b0;
    oPS2_DAT_OE = 1'b0;
    oBusy       = 1'b1;
    oDone       = 1'b0;
    oErr        = 1'b0;

    case (state_reg)
      IDLE: begin
        oBusy = 1'b0;
        if (iStart) begin
          data_next   = iData;
          parity_next = ~^iData;
          cnt_next    = '0;
          n_next      = '0;
          nack_next   = 1'b0;
          state_next  = INHIBIT;
        end
      end
      INHIBIT: begin
        oPS2_CLK_OE = 1'b1;
        if (cnt_reg == INH_LAST) begin
          cnt_next   = '0;
          state_next = REQ;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      REQ: begin
        oPS2_CLK_OE = 1'b1;
        oPS2_DAT_OE = 1'b1;
        cnt_next    = '0;
        n_next      = '0;
        state_next  = SEND;
      end
      SEND: begin
        oPS2_DAT_OE = ~frame_bits[n_reg];
        if (fall) begin
          cnt_next = '0;
          n_next   = n_reg + 4'd1;
          if (n_reg == 4'd9) state_next = ACK;
        end else if (cnt_reg == TMO_LAST) begin
          nack_next  = 1'b1;
          state_next = FINISH;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ACK: begin
        if (fall) begin
          cnt_next   = '0;
          n_next     = n_reg + 4'd1;
          nack_next  = dat_sync;
          state_next = FINISH;
        end else if (cnt_reg == TMO_LAST) begin
          nack_next  = 1'b1;
          state_next = FINISH;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FINISH: begin
        // Timeout also lands here with nack set, so both lines are already released.
        oBusy      = 1'b0;
        oDone      = ~nack_reg;
        oErr       = nack_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// compares captured bits and completion pulses against frames built from the byte.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 2500;
  localparam int TMO = 12000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iStart = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       clk_oe, dat_oe, busy, done, err;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       glitch_en = 1'b0;
  logic       glitch_val = 1'b1;
  logic       line_clk, line_dat, clk_in;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  int cyc = 0;
  int err_cyc = 0;

  // Open-drain wired-AND of host and device; glitch_en overrides the raw clock input.
  assign line_clk = ~clk_oe & dev_clk;
  assign line_dat = ~dat_oe & dev_dat;
  assign clk_in   = glitch_en ? glitch_val : line_clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .iStart(iStart), .iData(iData),
    .iPS2_CLK(clk_in), .iPS2_DAT(line_dat),
    .oPS2_CLK_OE(clk_oe), .oPS2_DAT_OE(dat_oe),
    .oBusy(busy), .oDone(done), .oErr(err)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if ((done && err) || ((done || err) && busy)) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    int ones;
    ones = $countones(d);
    exp_frame = {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  task automatic host_start(input logic [7:0] d);
    iData  = d;
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
  endtask

  task automatic host_phase(input string tag, input int poke_at, input logic [7:0] poke_d,
                            input bit glitchy);
    int inh;
    inh = 0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (clk_oe === 1'b1 && dat_oe === 1'b0 && inh < INH + 20) begin
      iStart = (inh == poke_at);
      if (inh == poke_at) iData = poke_d;
      if (glitchy && inh >= 20 && inh < 200) begin
        glitch_en  = 1'b1;
        glitch_val = ((inh / 3) % 2 == 0);
      end else begin
        glitch_en = 1'b0;
      end
      tick(1);
      inh++;
    end
    iStart    = 1'b0;
    glitch_en = 1'b0;
    check({tag, "_inhibit_len"}, 32'(inh), 32'(INH));
    check({tag, "_req_oe"}, {30'd0, clk_oe, dat_oe}, 32'd3);
    tick(1);
    check({tag, "_start_oe"}, {30'd0, clk_oe, dat_oe}, 32'd1);
  endtask

  // Device: samples the start bit before the first fall, then each bit at the rising edge.
  task automatic device(input int hp, input int n_edges, input bit nack, input int reset_at,
                        output logic [10:0] frame, output int fall_cyc);
    int w;
    w = 0;
    frame = '1;
    fall_cyc = 0;
    while (!(clk_oe === 1'b0 && dat_oe === 1'b1) && w < 100) begin
      tick(1);
      w++;
    end
    tick(hp);
    frame[0] = line_dat;
    for (int i = 1; i <= n_edges; i++) begin
      dev_clk  = 1'b0;
      fall_cyc = cyc;
      if (i == reset_at) begin
        tick(5);
        reset = 1'b1;
        tick(1);
        reset   = 1'b0;
        dev_clk = 1'b1;
        return;
      end
      tick(hp);
      dev_clk = 1'b1;
      tick(2);
      if (i <= 10) frame[i] = line_dat;
      if (i == 10) dev_dat = nack;
      if (i == 11) dev_dat = 1'b1;
      tick(hp - 2);
    end
  endtask

  task automatic full_frame(input string tag, input logic [7:0] d, input int hp, input bit nack,
                            input int poke_at, input logic [7:0] poke_d, input bit glitchy);
    int d0, e0, fc;
    logic [10:0] fr;
    d0 = done_cnt;
    e0 = err_cnt;
    host_start(d);
    host_phase(tag, poke_at, poke_d, glitchy);
    device(hp, 11, nack, 0, fr, fc);
    tick(4);
    $display("frame %s data=%02h hp=%0d nack=%0d captured=%03h", tag, d, hp, nack, fr);
    check({tag, "_frame"}, 32'(fr), 32'(exp_frame(d)));
    check({tag, "_done"}, 32'(done_cnt - d0), nack ? 32'd0 : 32'd1);
    check({tag, "_err"}, 32'(err_cnt - e0), nack ? 32'd1 : 32'd0);
    check({tag, "_end_state"}, {29'd0, clk_oe, dat_oe, busy}, 32'd0);
  endtask

  initial begin
    int d0, e0, w, fc;
    logic [10:0] fr;
    logic [7:0] rd;
    int rhp;
    bit rnack;

    tick(3);
    check("reset_outputs", {27'd0, clk_oe, dat_oe, busy, done, err}, 32'd0);
    reset = 1'b0;
    tick(2);
    check("idle_outputs", {27'd0, clk_oe, dat_oe, busy, done, err}, 32'd0);

    full_frame("ed_ack", 8'hED, 20, 1'b0, -1, 8'h00, 1'b0);
    full_frame("f4_nack", 8'hF4, 20, 1'b1, -1, 8'h00, 1'b0);

    // Device stops clocking after five edges.
    d0 = done_cnt;
    e0 = err_cnt;
    host_start(8'hFF);
    host_phase("tmo", -1, 8'h00, 1'b0);
    device(20, 5, 1'b0, 0, fr, fc);
    w = 0;
    while (err_cnt == e0 && w < TMO + 200) begin
      tick(1);
      w++;
    end
    tick(2);
    $display("timeout data=ff err_delay=%0d", err_cyc - fc);
    check("tmo_partial_frame", 32'(fr[5:0]), 32'(exp_frame(8'hFF) & 11'h03F));
    check("tmo_delay_in_window", 32'((err_cyc - fc >= TMO) && (err_cyc - fc <= TMO + 4)), 32'd1);
    check("tmo_err", 32'(err_cnt - e0), 32'd1);
    check("tmo_done", 32'(done_cnt - d0), 32'd0);
    check("tmo_released", {29'd0, clk_oe, dat_oe, busy}, 32'd0);

    // Second request during inhibit must be dropped.
    full_frame("dbl_start", 8'h5A, 20, 1'b0, 10, 8'hC3, 1'b0);
    tick(60);
    check("dbl_no_second_frame", {30'd0, clk_oe, busy}, 32'd0);

    // Reset at the sixth edge, then a clean 0x00 frame.
    d0 = done_cnt;
    e0 = err_cnt;
    host_start(8'hED);
    host_phase("mid_rst", -1, 8'h00, 1'b0);
    device(20, 11, 1'b0, 6, fr, fc);
    check("mid_rst_released", {29'd0, clk_oe, dat_oe, busy}, 32'd0);
    tick(10);
    $display("mid-transfer reset done=%0d err=%0d", done_cnt - d0, err_cnt - e0);
    check("mid_rst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    full_frame("after_rst_00", 8'h00, 20, 1'b0, -1, 8'h00, 1'b0);

    full_frame("glitch_ed", 8'hED, 20, 1'b0, -1, 8'h00, 1'b1);

    for (int k = 0; k < 4; k++) begin
      rd    = 8'($urandom_range(0, 255));
      rhp   = $urandom_range(8, 30);
      rnack = 1'($urandom_range(0, 1));
      full_frame("rnd", rd, rhp, rnack, -1, 8'h00, 1'b0);
    end

    check("done_err_exclusive", 32'(overlap_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 2500, SHALL set the clock-inhibit hold: 100 us at 25 MHz.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, SHALL set the maximum gap between device clock falling edges: 2 ms at 25 MHz.
REQ-003 clk  input  1  SHALL be the single clock, the 25 MHz system clock; all logic on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 iStart  input  1  SHALL be a one-cycle request to send iData; it is ignored while oBusy=1.
REQ-006 iData  input  8  SHALL be the command byte, sampled when iStart is accepted.
REQ-007 iPS2_CLK  input  1  SHALL be the raw PS2 clock line, asynchronous.
REQ-008 iPS2_DAT  input  1  SHALL be the raw PS2 data line, asynchronous.
REQ-009 oPS2_CLK_OE  output  1  SHALL pull the PS2 clock low when 1 (open-drain); the line is released when 0.
REQ-010 oPS2_DAT_OE  output  1  SHALL pull the PS2 data low when 1 (open-drain); the line is released when 0.
REQ-011 oBusy  output  1  SHALL be 1 from iStart acceptance until oDone/oErr; the keyboard receiver masks its input while it is 1.
REQ-012 oDone  output  1  SHALL be a one-cycle pulse when the device acknowledges.
REQ-013 oErr  output  1  SHALL be a one-cycle pulse on NACK or timeout.

Function
REQ-014 iPS2_CLK and iPS2_DAT SHALL each pass through a 2-FF synchronizer; a falling edge is detected as sync_prev=1 and sync=0 (3 cycles of input-to-detect latency).
REQ-015 States SHALL be: IDLE, INHIBIT, REQ, SEND, ACK, FINISH.
REQ-016 IDLE: both OEs 0, oBusy 0; iStart=1 latches iData, computes parity = ~^iData (odd), clears counters, goes to INHIBIT on the next cycle.
REQ-017 INHIBIT: oPS2_CLK_OE=1, oPS2_DAT_OE=0; the cycle counter runs INHIBIT_CYCLES cycles, then goes to REQ.
REQ-018 REQ: oPS2_CLK_OE=1, oPS2_DAT_OE=1 for exactly one cycle (data low before clock release); then goes to SEND.
REQ-019 SEND: oPS2_CLK_OE=0, oPS2_DAT_OE=1 (start bit 0) until the first falling edge.
REQ-020 The falling edge counter n SHALL start at 0; on each detected falling edge n increments.
  - n=1..8: drive data bit n-1 (LSB first); oPS2_DAT_OE = ~bit.
  - n=9: oPS2_DAT_OE = ~parity.
  - n=10: oPS2_DAT_OE=0 (stop bit, line released); go to ACK.
REQ-021 ACK: on the next falling edge (11th), sample synced data: 0 means ACK, 1 means NACK; go to FINISH.
REQ-022 FINISH: for one cycle assert oDone (ACK) or oErr (NACK); oBusy drops in the same cycle; return to IDLE.
REQ-023 In SEND/ACK the timeout counter SHALL clear on each falling edge; on reaching TIMEOUT_CYCLES, release both OEs, pulse oErr, go to IDLE.
REQ-024 oDone and oErr SHALL never assert in the same cycle.
REQ-025 iStart asserted in FINISH or any non-IDLE state SHALL be dropped, not queued.
REQ-026 Falling edges seen in IDLE, INHIBIT or REQ SHALL be ignored; n does not change.
REQ-027 Counters SHALL be wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES) without wrap; n is 4 bits.

Reset
REQ-028 While reset=1: state IDLE; oPS2_CLK_OE, oPS2_DAT_OE, oBusy, oDone, oErr all 0; synchronizers preset to 1; counters 0.
REQ-029 Reset mid-transfer SHALL release both lines on the next clock edge with no oDone/oErr pulse.

Verification
REQ-030 iData=0xED, device model ACKs: clock held low 2500 cycles, then 1 cycle with both OEs, then bits 1,0,1,1,0,1,1,1, parity 1, stop; one oDone pulse, oErr=0.
REQ-031 iData=0xF4, device drives data high at the 11th edge: parity bit 0 is sent, then one oErr pulse and no oDone.
REQ-032 iData=0xFF, device stops clocking after 5 edges: oErr pulses 50000 cycles after the 5th edge; both OEs go 0.
REQ-033 A second iStart at cycle 10 of INHIBIT: ignored; exactly one frame is sent and latched data is unchanged.
REQ-034 reset=1 at edge 6 of 0xED: next cycle OEs=0, oBusy=0, no pulses; a new iStart=0x00 then completes normally with parity 1.
REQ-035 Glitch-free check: spurious falling edges on iPS2_CLK during INHIBIT do not advance n; the frame still matches REQ-030.
